// File: rtl/dmem_responder_if.sv
// dmem_responder_if: CPU data-memory port plus host-side TX drain port.
//   d_addr/d_dataout/d_we : CPU word address, write data and write enable
//   d_datain              : read data back to the CPU (combinational)
//   count_en              : cycle counter enable
//   tx_valid/tx_data      : head of the output FIFO
//   tx_ready              : host accepts the head word
interface dmem_responder_if;
    logic [15:0] d_addr, d_dataout, d_datain, tx_data;
    logic        d_we, count_en, tx_valid, tx_ready;
    modport master (output d_addr, d_dataout, d_we, count_en, tx_ready,
                    input  d_datain, tx_valid, tx_data);
    modport slave  (input  d_addr, d_dataout, d_we, count_en, tx_ready,
                    output d_datain, tx_valid, tx_data);
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: data RAM plus an I/O page (TX FIFO, status, coherent cycle counter).
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : dmem_responder_if.slave (CPU data port and host TX drain port)
module dmem_responder #(
    parameter int RAM_AW  = 8,
    parameter int FIFO_AW = 2
) (
    input logic             clock,
    input logic             reset,
    dmem_responder_if.slave bus
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);
    logic [15:0] ram [1 << RAM_AW];
    logic [15:0] fifo [DEPTH];
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               overflow_q, overflow_d, bad_addr_q, bad_addr_d;
    logic [31:0]        cyc_q, cyc_d;
    logic [15:0]        hi_snap_q, hi_snap_d, status;
    logic ram_hit, is_tx, is_st, is_lo, is_hi, empty, full, pop, push_req, push, st_wr;
    always_comb begin
        ram_hit    = (bus.d_addr >> RAM_AW) == 16'd0;
        is_tx      = bus.d_addr == 16'hFF00;
        is_st      = bus.d_addr == 16'hFF01;
        is_lo      = bus.d_addr == 16'hFF02;
        is_hi      = bus.d_addr == 16'hFF03;
        empty      = count_q == '0;
        full       = count_q == FULL_CNT;
        pop        = !empty && bus.tx_ready;
        push_req   = bus.d_we && is_tx;
        // a pop on the same edge frees the slot, so a full FIFO still accepts
        push       = push_req && (!full || pop);
        st_wr      = bus.d_we && is_st;
        status     = {12'b0, bad_addr_q, overflow_q, full, empty};
        rd_ptr_d   = rd_ptr_q + FIFO_AW'(pop);
        wr_ptr_d   = wr_ptr_q + FIFO_AW'(push);
        count_d    = count_q + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);
        // sticky flags: a set on the same edge as a clear wins
        overflow_d = (push_req && !push) || (overflow_q && !(st_wr && bus.d_dataout[2]));
        bad_addr_d = (bus.d_we && !ram_hit && !is_tx && !is_st && !is_lo && !is_hi)
                     || (bad_addr_q && !(st_wr && bus.d_dataout[3]));
        cyc_d      = cyc_q + 32'(bus.count_en);
        // snapshot the pre-increment high half so CYC_HI pairs with this CYC_LO read
        hi_snap_d  = (is_lo && !bus.d_we) ? cyc_q[31:16] : hi_snap_q;
    end
    assign bus.d_datain = ram_hit ? ram[bus.d_addr[RAM_AW-1:0]] :
                          is_st   ? status :
                          is_lo   ? cyc_q[15:0] :
                          is_hi   ? hi_snap_q : 16'h0000;
    assign bus.tx_valid = !empty;
    assign bus.tx_data  = empty ? 16'h0000 : fifo[rd_ptr_q];
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            bad_addr_q <= 1'b0;
            cyc_q      <= '0;
            hi_snap_q  <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            bad_addr_q <= bad_addr_d;
            cyc_q      <= cyc_d;
            hi_snap_q  <= hi_snap_d;
        end
    end
    always_ff @(posedge clock) begin
        if (push) fifo[wr_ptr_q] <= bus.d_dataout;
        if (bus.d_we && ram_hit) ram[bus.d_addr[RAM_AW-1:0]] <= bus.d_dataout;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: queue-based model check every cycle plus directed literal checks.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    dmem_responder_if bus ();
    dmem_responder dut (.clock(clk), .reset(rst), .bus(bus));
    always #5 clk = ~clk;

    logic [15:0] mq[$];
    logic [15:0] mram [256];
    bit          mwr  [256];
    bit          movf, mbad;
    logic [31:0] mcnt;
    logic [15:0] mhi;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        movf = 0;
        mbad = 0;
        mcnt = 0;
        mhi  = 0;
    endtask

    function automatic logic [15:0] m_status();
        return {12'b0, mbad, movf, mq.size() == 4, mq.size() == 0};
    endfunction

    // applies one rising edge using the inputs held during the ending cycle
    task automatic model_step();
        logic [15:0] a, d;
        bit we, pop;
        int sz;
        if (rst) begin
            model_reset();
            return;
        end
        a = bus.d_addr;
        d = bus.d_dataout;
        we = bus.d_we;
        sz = mq.size();
        pop = sz > 0 && bus.tx_ready;
        if (we && a == 16'hFF01) begin
            if (d[2]) movf = 0;
            if (d[3]) mbad = 0;
        end
        if (pop) void'(mq.pop_front());
        if (we && a == 16'hFF00) begin
            if (sz < 4 || pop) mq.push_back(d);
            else movf = 1;
        end
        if (we && a >= 16'd256 && !(a inside {[16'hFF00:16'hFF03]})) mbad = 1;
        if (!we && a == 16'hFF02) mhi = mcnt[31:16];
        mcnt = mcnt + 32'(bus.count_en);
        if (we && a < 16'd256) begin
            mram[a[7:0]] = d;
            mwr[a[7:0]] = 1;
        end
    endtask

    initial forever begin
        @(negedge clk);
        chk("tx_valid", 32'(bus.tx_valid), 32'(mq.size() != 0));
        chk("tx_data", 32'(bus.tx_data), mq.size() != 0 ? 32'(mq[0]) : 32'h0);
        if (bus.d_addr < 16'd256) begin
            if (mwr[bus.d_addr[7:0]]) chk("d_datain_ram", 32'(bus.d_datain), 32'(mram[bus.d_addr[7:0]]));
        end else begin
            chk("d_datain_io", 32'(bus.d_datain),
                bus.d_addr == 16'hFF01 ? 32'(m_status()) :
                bus.d_addr == 16'hFF02 ? 32'(mcnt[15:0]) :
                bus.d_addr == 16'hFF03 ? 32'(mhi) : 32'h0);
        end
    end

    task automatic cyc(input logic [15:0] a, input logic we, input logic [15:0] d,
                       input logic rdy, input logic cen);
        @(posedge clk);
        model_step();
        #1;
        bus.d_addr = a;
        bus.d_we = we;
        bus.d_dataout = d;
        bus.tx_ready = rdy;
        bus.count_en = cen;
    endtask

    task automatic lit(input string name, input logic [15:0] exp);
        #1 chk(name, 32'(bus.d_datain), 32'(exp));
    endtask

    initial begin
        model_reset();
        bus.d_addr = 16'hFF01;
        bus.d_we = 0;
        bus.d_dataout = 0;
        bus.tx_ready = 0;
        bus.count_en = 0;
        #1 chk("reset_tx_valid", 32'(bus.tx_valid), 32'h0);
        lit("reset_status", 16'h0001);
        @(posedge clk);
        model_step();
        #1 rst = 0;

        repeat (65535) cyc(16'h4001, 0, 0, 0, 1);
        cyc(16'hFF02, 0, 0, 0, 1); lit("cyc_lo_ffff", 16'hFFFF);
        cyc(16'hFF03, 0, 0, 0, 0); lit("cyc_hi_snap", 16'h0000);
        cyc(16'hFF02, 0, 0, 0, 0); lit("cyc_lo_wrap", 16'h0000);
        cyc(16'hFF03, 0, 0, 0, 0); lit("cyc_hi_one", 16'h0001);
        cyc(16'hFF02, 0, 0, 0, 0); lit("cyc_lo_hold", 16'h0000);

        cyc(16'h0005, 1, 16'h1234, 0, 0);
        cyc(16'h0005, 0, 0, 0, 0);          lit("ram5", 16'h1234);
        cyc(16'h0006, 1, 16'hBEEF, 0, 0);
        cyc(16'h0006, 0, 0, 0, 0);          lit("ram6", 16'hBEEF);
        cyc(16'h0005, 1, 16'h5555, 0, 0);   lit("ram_old", 16'h1234);
        cyc(16'h0005, 0, 0, 0, 0);          lit("ram_new", 16'h5555);

        for (int i = 0; i < 4; i++) cyc(16'hFF00, 1, 16'h00A1 + 16'(i), 0, 0);
        cyc(16'hFF01, 0, 0, 0, 0);          lit("st_full", 16'h0002);
        chk("head_a1", 32'(bus.tx_data), 32'h00A1);
        cyc(16'hFF00, 1, 16'h00A5, 0, 0);
        cyc(16'hFF01, 0, 0, 0, 0);          lit("st_ovf", 16'h0006);
        cyc(16'hFF01, 1, 16'h0004, 0, 0);
        cyc(16'hFF01, 0, 0, 0, 0);          lit("st_clr_ovf", 16'h0002);
        for (int i = 0; i < 4; i++) begin
            cyc(16'hFF01, 0, 0, 1, 0);
            #1 chk("drain_a", 32'(bus.tx_data), 32'h00A1 + 32'(i));
        end
        cyc(16'hFF01, 0, 0, 0, 0);          lit("st_empty", 16'h0001);
        chk("drained_valid", 32'(bus.tx_valid), 32'h0);

        for (int i = 0; i < 4; i++) cyc(16'hFF00, 1, 16'h00B0 + 16'(i), 0, 0);
        cyc(16'hFF00, 1, 16'h00B4, 1, 0);
        #1 chk("head_b0", 32'(bus.tx_data), 32'h00B0);
        cyc(16'hFF01, 0, 0, 0, 0);          lit("st_pushpop", 16'h0002);
        for (int i = 1; i <= 4; i++) begin
            cyc(16'hFF01, 0, 0, 1, 0);
            #1 chk("drain_b", 32'(bus.tx_data), 32'h00B0 + 32'(i));
        end
        cyc(16'hFF01, 0, 0, 0, 0);          lit("st_empty_b", 16'h0001);

        cyc(16'h0000, 1, 16'h0AAA, 0, 0);
        cyc(16'h4000, 1, 16'h7777, 0, 0);
        cyc(16'h4000, 0, 0, 0, 0);          lit("bad_read", 16'h0000);
        cyc(16'hFF01, 0, 0, 0, 0);          lit("st_bad", 16'h0009);
        cyc(16'h0000, 0, 0, 0, 0);          lit("ram0_kept", 16'h0AAA);
        cyc(16'hFF01, 1, 16'h0008, 0, 0);
        cyc(16'hFF01, 0, 0, 0, 0);          lit("st_bad_clr", 16'h0001);

        for (int i = 0; i < 5; i++) cyc(16'hFF00, 1, 16'h00C1 + 16'(i), 0, 0);
        cyc(16'hFF01, 0, 0, 1, 0);          lit("st_pre_rst", 16'h0006);
        cyc(16'hFF01, 0, 0, 0, 0);          lit("st_three", 16'h0004);
        #1 rst = 1;
        model_reset();
        #1 chk("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'h0);
        chk("rst_status", 32'(bus.d_datain), 32'h0001);
        cyc(16'hFF02, 0, 0, 0, 0);          lit("rst_cyc_lo", 16'h0000);
        cyc(16'hFF03, 0, 0, 0, 0);          lit("rst_cyc_hi", 16'h0000);
        cyc(16'h0005, 0, 0, 0, 0);          lit("rst_ram5", 16'h5555);
        @(posedge clk);
        model_step();
        #1 rst = 0;
        cyc(16'hFF00, 1, 16'h00D1, 0, 0);
        cyc(16'hFF01, 0, 0, 0, 0);          lit("st_post_rst", 16'h0000);
        chk("head_d1", 32'(bus.tx_data), 32'h00D1);
        cyc(16'hFF01, 0, 0, 0, 0);
        @(posedge clk);
        #1 $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
